// File: rtl/cpu_run_controller_if.sv
// Dump/stream bundle between the run controller and the data-RAM / log side.
//
// Signals:
//   dumpAddr  - word address driven to data RAM read port 2
//   dumpRdata - RAM port 2 read data, valid one cycle after dumpAddr
//   outValid  - dump word available on outData
//   outReady  - consumer accepts the current word
//   outData   - dump word
//   outLast   - marks the word read from the final RAM address
//
// master: the run controller. slave: the RAM read port plus the log consumer.
interface cpu_run_controller_if #(
    parameter int ADDR_W = 9
);
    logic [ADDR_W-1:0] dumpAddr;
    logic [31:0]       dumpRdata;
    logic              outValid;
    logic              outReady;
    logic [31:0]       outData;
    logic              outLast;

    modport master (
        output dumpAddr,
        input  dumpRdata,
        output outValid,
        input  outReady,
        output outData,
        output outLast
    );

    modport slave (
        input  dumpAddr,
        output dumpRdata,
        input  outValid,
        output outReady,
        input  outData,
        input  outLast
    );
endinterface

// File: rtl/cpu_run_controller.sv
// Sequences one complete program run of the pipelined CPU: holds the core in
// reset, releases it, counts run cycles, detects halt or timeout, lets the
// pipeline drain with fetch frozen, then streams the whole data RAM out over
// a valid/ready port.
//
// Ports:
//   clk           - system clock, rising edge
//   rst           - asynchronous active-high reset
//   start_i       - begin a run (honoured only in IDLE or FINISH)
//   haltDetect_i  - halt instruction seen in ID
//   cpuReset_o    - holds the CPU core in reset
//   cpuHold_o     - freezes PC and bubbles IF/ID
//   cycleCount_o  - RUN cycles of the current/last run (saturating)
//   done_o        - run and dump complete
//   timeout_o     - run ended by MAX_CYCLES rather than by halt
//   dump          - RAM read port 2 and output stream (master side)
module cpu_run_controller #(
    parameter int RAM_WORDS  = 512,
    parameter int ADDR_W     = 9,
    parameter int MAX_CYCLES = 1000,
    parameter int PIPE_DRAIN = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic                        haltDetect_i,
    output logic                        cpuReset_o,
    output logic                        cpuHold_o,
    output logic [31:0]                 cycleCount_o,
    output logic                        done_o,
    output logic                        timeout_o,
    cpu_run_controller_if.master        dump
);

    localparam int DRAIN_W = (PIPE_DRAIN > 1) ? $clog2(PIPE_DRAIN) : 1;
    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(RAM_WORDS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_DRAIN - 1);
    localparam logic [31:0]        MAX_COUNT  = 32'(MAX_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DUMP,
        S_FINISH
    } state_t;

    state_t               state_q, state_d;
    logic                 clearCnt_q, clearCnt_d;
    logic [DRAIN_W-1:0]   drainCnt_q, drainCnt_d;
    logic [31:0]          cycleCount_q, cycleCount_d;
    logic                 timeout_q, timeout_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 allIssued_q, allIssued_d;
    logic                 rdValid_q, rdValid_d;
    logic                 rdLast_q, rdLast_d;
    logic [1:0]           fifoCnt_q, fifoCnt_d;
    logic [31:0]          data0_q, data0_d, data1_q, data1_d;
    logic                 last0_q, last0_d, last1_q, last1_d;

    logic                 pop;
    logic                 push;
    logic [1:0]           occAfterPop;
    logic                 issue;
    logic                 startRun;

    // Entry 0 of the FIFO is the head presented on the output port.
    assign pop         = (fifoCnt_q != 2'd0) && dump.outReady;
    assign push        = rdValid_q;
    assign occAfterPop = fifoCnt_q - {1'b0, pop};
    // A read in flight always lands next cycle, so it counts as a reserved slot.
    assign issue       = (state_q == S_DUMP) && !allIssued_q &&
                         ((occAfterPop + {1'b0, rdValid_q}) < 2'd2);
    assign startRun    = start_i && ((state_q == S_IDLE) || (state_q == S_FINISH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            clearCnt_q   <= 1'b0;
            drainCnt_q   <= '0;
            cycleCount_q <= '0;
            timeout_q    <= 1'b0;
            addr_q       <= '0;
            allIssued_q  <= 1'b0;
            rdValid_q    <= 1'b0;
            rdLast_q     <= 1'b0;
            fifoCnt_q    <= '0;
            data0_q      <= '0;
            data1_q      <= '0;
            last0_q      <= 1'b0;
            last1_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            clearCnt_q   <= clearCnt_d;
            drainCnt_q   <= drainCnt_d;
            cycleCount_q <= cycleCount_d;
            timeout_q    <= timeout_d;
            addr_q       <= addr_d;
            allIssued_q  <= allIssued_d;
            rdValid_q    <= rdValid_d;
            rdLast_q     <= rdLast_d;
            fifoCnt_q    <= fifoCnt_d;
            data0_q      <= data0_d;
            data1_q      <= data1_d;
            last0_q      <= last0_d;
            last1_q      <= last1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clearCnt_d   = clearCnt_q;
        drainCnt_d   = drainCnt_q;
        cycleCount_d = cycleCount_q;
        timeout_d    = timeout_q;
        addr_d       = addr_q;
        allIssued_d  = allIssued_q;
        rdValid_d    = 1'b0;
        rdLast_d     = 1'b0;
        fifoCnt_d    = fifoCnt_q - {1'b0, pop} + {1'b0, push};
        data0_d      = data0_q;
        data1_d      = data1_q;
        last0_d      = last0_q;
        last1_d      = last1_q;

        case (state_q)
            S_CLEAR: begin
                clearCnt_d = 1'b1;
                if (clearCnt_q) begin
                    clearCnt_d = 1'b0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (cycleCount_q < MAX_COUNT) begin
                    cycleCount_d = cycleCount_q + 32'd1;
                end
                drainCnt_d = '0;
                // Halt takes priority when it coincides with the final count.
                if (haltDetect_i) begin
                    state_d = S_DRAIN;
                end else if ((cycleCount_q + 32'd1) >= MAX_COUNT) begin
                    timeout_d = 1'b1;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                drainCnt_d = drainCnt_q + 1'b1;
                if (drainCnt_q == DRAIN_LAST) begin
                    state_d = S_DUMP;
                end
            end
            S_DUMP: begin
                if (pop && last0_q) begin
                    state_d = S_FINISH;
                end
            end
            default: begin
            end
        endcase

        // The address parks on the final word instead of wrapping.
        if (issue) begin
            rdValid_d = 1'b1;
            rdLast_d  = (addr_q == LAST_ADDR);
            if (addr_q == LAST_ADDR) begin
                allIssued_d = 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end

        case ({pop, push})
            2'b01: begin
                if (fifoCnt_q == 2'd0) begin
                    data0_d = dump.dumpRdata;
                    last0_d = rdLast_q;
                end else begin
                    data1_d = dump.dumpRdata;
                    last1_d = rdLast_q;
                end
            end
            2'b10: begin
                data0_d = data1_q;
                last0_d = last1_q;
            end
            2'b11: begin
                if (fifoCnt_q == 2'd1) begin
                    data0_d = dump.dumpRdata;
                    last0_d = rdLast_q;
                end else begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    data1_d = dump.dumpRdata;
                    last1_d = rdLast_q;
                end
            end
            default: begin
            end
        endcase

        // A new run wipes the previous run's results and any dump progress.
        if (startRun) begin
            state_d      = S_CLEAR;
            clearCnt_d   = 1'b0;
            cycleCount_d = '0;
            timeout_d    = 1'b0;
            addr_d       = '0;
            allIssued_d  = 1'b0;
            rdValid_d    = 1'b0;
            rdLast_d     = 1'b0;
            fifoCnt_d    = '0;
        end
    end

    assign cpuReset_o    = (state_q == S_IDLE) || (state_q == S_CLEAR);
    assign cpuHold_o     = (state_q == S_DRAIN) || (state_q == S_DUMP) || (state_q == S_FINISH);
    assign cycleCount_o  = cycleCount_q;
    assign done_o        = (state_q == S_FINISH);
    assign timeout_o     = timeout_q;
    assign dump.dumpAddr = addr_q;
    assign dump.outValid = (fifoCnt_q != 2'd0);
    assign dump.outData  = data0_q;
    assign dump.outLast  = last0_q && (fifoCnt_q != 2'd0);

endmodule

// File: doc/cpu_run_controller.md
# cpu_run_controller

Sequences one complete program run of the pipelined CPU: holds the core in reset, releases it, counts run cycles, and detects halt or timeout. It then freezes fetch, lets the pipeline drain, and streams the whole data RAM out over a valid/ready port. It sits between the CPU top level and the simulation/log infrastructure, so halt detection and memory dumping are done in hardware rather than by hierarchical probing.

## Interface
- RAM_WORDS, 512, number of 32-bit data RAM words dumped
- ADDR_W, 9, dump address width (log2 RAM_WORDS)
- MAX_CYCLES, 1000, RUN cycles before forced stop
- PIPE_DRAIN, 4, cycles the pipeline runs after halt before dumping

Ports (one clock; RESET is asynchronous and active-high):
- CLOCK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  begin a run; sampled only in IDLE or FINISH
- HALT_DETECT  in  1  from CPU decode: halt instruction (0xFFFFFFFF) in ID
- CPU_RESET  out  1  holds the CPU core in reset
- CPU_HOLD  out  1  freezes PC and bubbles IF/ID; later stages keep running
- DUMP_ADDR  out  ADDR_W  word address to data RAM read port 2
- DUMP_RDATA  in  32  RAM port 2 data, valid one cycle after DUMP_ADDR is issued
- OUT_VALID  out  1  dump word available
- OUT_READY  in  1  consumer accepts the word
- OUT_DATA  out  32  dump word
- OUT_LAST  out  1  marks word RAM_WORDS-1
- CYCLE_COUNT  out  32  RUN cycles of current/last run
- DONE  out  1  run and dump complete
- TIMEOUT  out  1  run ended by MAX_CYCLES, not by halt

## Operation
- Reset values: CPU_RESET=1, CPU_HOLD=0, DUMP_ADDR=0, OUT_VALID=0, OUT_DATA=0, OUT_LAST=0, CYCLE_COUNT=0, DONE=0, TIMEOUT=0. State is IDLE.
- States: IDLE, CLEAR, RUN, DRAIN, DUMP, FINISH.
- IDLE: CPU_RESET=1. START goes to CLEAR and clears CYCLE_COUNT, TIMEOUT and DONE.
- CLEAR: CPU_RESET=1 for exactly 2 cycles, then RUN.
- RUN: CPU_RESET=0. CYCLE_COUNT increments by 1 every cycle.
  - HALT_DETECT goes to DRAIN.
  - If the count reaches MAX_CYCLES without halt: set TIMEOUT, go to DRAIN.
  - HALT_DETECT in the same cycle the count reaches MAX_CYCLES: halt wins, TIMEOUT stays 0.
- DRAIN: CPU_HOLD=1 for PIPE_DRAIN cycles so in-flight stores retire, then DUMP. CYCLE_COUNT is frozen.
- DUMP: CPU_HOLD stays 1.
  - Reads are issued at addresses 0..RAM_WORDS-1 in order.
  - Read data goes into a 2-entry output FIFO.
  - A read is issued in a cycle only if (FIFO occupancy after this cycle's pop) + reads in flight < 2. No word is ever dropped or duplicated.
  - OUT_LAST=1 exactly with the word from address RAM_WORDS-1.
  - The handshake of that last word moves the FSM to FINISH.
- FINISH: DONE=1, CPU_HOLD=1, CPU_RESET=0 (register state is kept for inspection). START goes to CLEAR.
- START in CLEAR, RUN, DRAIN or DUMP is ignored.
- DUMP_ADDR does not wrap past RAM_WORDS-1.
- CYCLE_COUNT saturates at MAX_CYCLES.

## Timing
- START high at edge k in IDLE: CPU_RESET=1 during cycles k+1 and k+2, CPU_RESET=0 from cycle k+3 (first RUN cycle).
- CYCLE_COUNT reads 1 after the first RUN edge. A halt sampled on the n-th RUN edge leaves CYCLE_COUNT=n.
- CPU_HOLD rises the cycle after the halt or timeout edge.
- DUMP is entered PIPE_DRAIN cycles after CPU_HOLD rises.
- First OUT_VALID appears 2 cycles after entering DUMP: address issue, then RAM latency.
- With OUT_READY held high, one word transfers per cycle: RAM_WORDS words in RAM_WORDS consecutive cycles.
- While OUT_VALID=1 and OUT_READY=0: OUT_DATA, OUT_LAST and OUT_VALID hold stable.
- DONE rises the cycle after the last handshake.
- RESET asserted in any state forces all outputs to reset values immediately (asynchronously). The dump does not resume: the next START restarts at word 0.

## Test plan
- Basic run: RAM model returns addr*3, HALT_DETECT on RUN edge 37 -> CYCLE_COUNT=37, TIMEOUT=0, 512 words 0,3,...,1533 in order, OUT_LAST only on word 511, DONE=1.
- Timeout: HALT_DETECT never asserted -> CYCLE_COUNT=1000, TIMEOUT=1, full 512-word dump still produced, DONE=1.
- Simultaneous events: HALT_DETECT on RUN edge 1000 -> TIMEOUT=0, CYCLE_COUNT=1000.
- Backpressure: OUT_READY held low 10 cycles at word 5, then randomly toggled -> outputs stable while stalled, exactly 512 unique in-order words, no read issued with 2 words buffered or in flight.
- Full throughput: OUT_READY=1 -> first OUT_VALID 2 cycles after DUMP entry, 512 consecutive valid cycles; START pulsed during RUN has no effect.
- Reset mid-dump after word 100 handshake -> all outputs at reset values (CPU_RESET=1) within the same cycle; new START -> CYCLE_COUNT=0, dump restarts at address 0.
